// File: rtl/imem_loader_if.sv
// Byte-stream input, control and instruction-memory write port of the boot loader.
interface imem_loader_if #(
  parameter int ADDR_W = 32
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              start;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  // Loader side: consumes the stream and drives the memory write port.
  modport master (
    input  rx_valid, rx_data, start,
    output rx_ready, we, waddr, wdata, cpu_hold, done, err
  );

  // Environment side: byte source, start control and memory/core sink.
  modport slave (
    output rx_valid, rx_data, start,
    input  rx_ready, we, waddr, wdata, cpu_hold, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a 16-bit word-count header
// followed by little-endian 32-bit words and writes them one per cycle.
// The core is held in reset until the whole image has been written.
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  imem_loader_if.master  bus
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [15:0]        r_len;
  logic [IDX_W-1:0]   r_word_idx;
  logic [1:0]         r_byte_cnt;
  logic [23:0]        r_shift;      // first three bytes of the word in progress
  logic               r_we;
  logic [ADDR_W-1:0]  r_waddr;
  logic [31:0]        r_wdata;
  logic               r_done;
  logic               r_err;

  logic               w_rx_ready;
  logic               w_accept;
  logic [15:0]        w_len_full;
  logic               w_len_bad;
  logic               w_last_word;

  // Full header as it will look once the high byte is taken this cycle.
  assign w_len_full  = {bus.rx_data, r_len[7:0]};
  assign w_len_bad   = (w_len_full == 16'd0) || (w_len_full > 16'(DEPTH));
  assign w_last_word = (16'(r_word_idx) == (r_len - 16'd1));
  assign w_accept    = bus.rx_valid && w_rx_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_LEN_LO;
    else       r_state <= w_state_next;
  end

  // Next-state logic and the state-decoded ready.
  always_comb begin
    w_state_next = r_state;
    w_rx_ready   = 1'b0;
    case (r_state)
      S_LEN_LO: begin
        w_rx_ready = 1'b1;
        if (bus.rx_valid) w_state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        w_rx_ready = 1'b1;
        if (bus.rx_valid) w_state_next = w_len_bad ? S_ERR : S_DATA;
      end
      S_DATA: begin
        w_rx_ready = 1'b1;
        if (bus.rx_valid && (r_byte_cnt == 2'd3)) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        w_state_next = w_last_word ? S_DONE : S_DATA;
      end
      S_DONE: begin
        if (bus.start) w_state_next = S_LEN_LO;
      end
      S_ERR: begin
        if (bus.start) w_state_next = S_LEN_LO;
      end
      default: w_state_next = S_LEN_LO;
    endcase
  end

  // Header capture, word assembly, write port and sticky status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_LEN_LO: begin
          if (w_accept) r_len[7:0] <= bus.rx_data;
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_len[15:8] <= bus.rx_data;
            r_word_idx  <= '0;
            r_byte_cnt  <= '0;
            if (w_len_bad) r_err <= 1'b1;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_shift    <= {bus.rx_data, r_shift[23:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              // Fourth byte lands in the top lane; launch the write next cycle.
              r_we    <= 1'b1;
              r_waddr <= ADDR_W'({r_word_idx, 2'b00});
              r_wdata <= {bus.rx_data, r_shift};
            end
          end
        end
        S_WRITE: begin
          if (w_last_word) r_done     <= 1'b1;
          else             r_word_idx <= r_word_idx + 1'b1;
        end
        S_DONE: begin
          if (bus.start) r_done <= 1'b0;
        end
        S_ERR: begin
          if (bus.start) r_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_ready = w_rx_ready;
  assign bus.we       = r_we;
  assign bus.waddr    = r_waddr;
  assign bus.wdata    = r_wdata;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.cpu_hold = (r_state != S_DONE);

endmodule
